// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: write port, two read ports, debug read, clear engine.
// wr_en is a single-cycle request with no ready: a write is refused only when wr_drop pulses the next cycle.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     rd_addr_a;
  logic [DATA_W-1:0]     rd_data_a;
  logic [ADDR_W-1:0]     rd_addr_b;
  logic [DATA_W-1:0]     rd_data_b;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  wr_drop;
  logic [1:0]            clr_state;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b, dbg_addr, clr_req,
    input  rd_data_a, rd_data_b, dbg_data, clr_busy, clr_done, wr_drop, clr_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b, dbg_addr, clr_req,
    output rd_data_a, rd_data_b, dbg_data, clr_busy, clr_done, wr_drop, clr_state
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file: 2 async read ports, debug read, byte-enabled write, bulk-clear FSM.
// Define REGFILE_BYPASS_EN to forward in-flight write bytes to read ports A/B.
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                wr_drop_q, wr_drop_d;
  logic                wr_zero;
  logic                wr_live;
  logic [DATA_W-1:0]   rd_a, rd_b, rd_dbg;

  // A write is live only in IDLE and never to the hardwired-zero entry.
  assign wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_live = bus.wr_en && (state_q == ST_IDLE) && !wr_zero;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = 1'b0;
    mem_d     = mem_q;
    if (wr_live) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) mem_d[bus.wr_addr][8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        mem_d[clr_cnt_q] = '0;
        wr_drop_d        = bus.wr_en;
        // Last entry is terminal: hold the counter instead of wrapping.
        if (&clr_cnt_q) state_d = ST_DONE;
        else            clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_DONE: begin
        wr_drop_d = bus.wr_en;
        clr_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    rd_a   = mem_q[bus.rd_addr_a];
    rd_b   = mem_q[bus.rd_addr_b];
    rd_dbg = mem_q[bus.dbg_addr];
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) rd_a   = '0;
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) rd_b   = '0;
    if ((ZERO_REG != 0) && (bus.dbg_addr  == '0)) rd_dbg = '0;
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < NB; i++) begin
      if (wr_live && bus.wr_be[i] && (bus.rd_addr_a == bus.wr_addr)) rd_a[8*i +: 8] = bus.wr_data[8*i +: 8];
      if (wr_live && bus.wr_be[i] && (bus.rd_addr_b == bus.wr_addr)) rd_b[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
`endif
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.dbg_data  = rd_dbg;
  assign bus.clr_busy  = (state_q == ST_CLEAR);
  assign bus.clr_done  = (state_q == ST_DONE);
  assign bus.wr_drop   = wr_drop_q;
  assign bus.clr_state = state_q;
endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param (default config, ZERO_REG=1).
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_register_file_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  register_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] model [DEPTH];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // driver tasks
  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.dbg_addr = '0; bus.clr_req = 1'b0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_be = '0;
    if (a != 5'd0) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic fill_all();
    for (int a = 0; a < DEPTH; a++) drive_write(5'(a), $urandom | 32'h1, 4'hF);
  endtask

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  task automatic pulse_clr_req();
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    // power-on: rst_n has been low since time 0
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr_a = 5'(a); bus.rd_addr_b = 5'(a); bus.dbg_addr = 5'(a);
      #1;
      n_tests++;
      if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0 || bus.dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL por_read addr=%0d a=%h b=%h dbg=%h expected 0", a, bus.rd_data_a, bus.rd_data_b, bus.dbg_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_all();
    bus.rd_addr_a = 5'd7;
    #1;
    n_tests++;
    if (bus.rd_data_a !== model[7]) begin
      n_fail++;
      $display("FAIL fill_read got=%h expected=%h", bus.rd_data_a, model[7]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.clr_busy !== 1'b0 || bus.wr_drop !== 1'b0 || bus.clr_done !== 1'b0 || bus.clr_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl busy=%b drop=%b done=%b state=%0d expected 0", bus.clr_busy, bus.wr_drop, bus.clr_done, bus.clr_state);
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr_a = 5'(a); bus.rd_addr_b = 5'(a); bus.dbg_addr = 5'(a);
      #1;
      n_tests++;
      if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0 || bus.dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d a=%h b=%h dbg=%h expected 0", a, bus.rd_data_a, bus.rd_data_b, bus.dbg_data);
      end
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [4:0]  a;
    logic [31:0] e;
    drive_write(5'd4, 32'h0000000B, 4'hF);
    bus.rd_addr_a = 5'd4;
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h0000000B) begin
      n_fail++;
      $display("FAIL wr_rd_4 got=%h expected=0000000b", bus.rd_data_a);
    end
    drive_write(5'd0, 32'hFFFFFFFF, 4'hF);
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0; bus.dbg_addr = 5'd0;
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0 || bus.dbg_data !== 32'h0 || bus.wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg a=%h b=%h dbg=%h drop=%b expected 0", bus.rd_data_a, bus.rd_data_b, bus.dbg_data, bus.wr_drop);
    end
    // read-during-write to the same address
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h00000055; bus.wr_be = 4'hF;
    bus.rd_addr_a = 5'd4; bus.dbg_addr = 5'd4;
    #1;
    n_tests++;
    if (bus.dbg_data !== 32'h0000000B || bus.rd_data_a !== (BYPASS ? 32'h00000055 : 32'h0000000B)) begin
      n_fail++;
      $display("FAIL rdw_same dbg=%h a=%h expected dbg=0000000b a=%h", bus.dbg_data, bus.rd_data_a,
               BYPASS ? 32'h00000055 : 32'h0000000B);
    end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_be = '0;
    model[4] = 32'h00000055;
    #1;
    n_tests++;
    if (bus.dbg_data !== 32'h00000055) begin
      n_fail++;
      $display("FAIL rdw_next got=%h expected=00000055", bus.dbg_data);
    end
    for (int k = 0; k < 8; k++) begin
      a = 5'($urandom_range(1, DEPTH - 1));
      drive_write(a, $urandom, 4'hF);
      bus.rd_addr_b = a;
      exp_q.push_back(model[a]);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.rd_data_b !== e) begin
        n_fail++;
        $display("FAIL wr_rd_rand addr=%0d got=%h expected=%h", a, bus.rd_data_b, e);
      end
    end
  endtask

  task automatic test_byte_enable();
    drive_write(5'd1, 32'h11223344, 4'hF);
    drive_write(5'd1, 32'hAABBCCDD, 4'b0101);
    bus.rd_addr_a = 5'd1;
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL be_0101 got=%h expected=11bb33dd", bus.rd_data_a);
    end
    drive_write(5'd1, 32'hFFFFFFFF, 4'b0000);
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h11BB33DD || bus.wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL be_none got=%h drop=%b expected=11bb33dd drop=0", bus.rd_data_a, bus.wr_drop);
    end
    drive_write(5'd1, 32'h99000000, 4'b1000);
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h99BB33DD) begin
      n_fail++;
      $display("FAIL be_1000 got=%h expected=99bb33dd", bus.rd_data_a);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    fill_all();
    pulse_clr_req();
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 6) begin
        n_tests++;
        if (bus.wr_drop !== 1'b1) begin
          n_fail++;
          $display("FAIL clr_drop got=%b expected=1", bus.wr_drop);
        end
      end
      if (cyc == 7) begin
        n_tests++;
        if (bus.wr_drop !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_drop_pulse got=%b expected=0", bus.wr_drop);
        end
      end
      if (cyc == 5) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
      end else begin
        bus.wr_en = 1'b0; bus.wr_be = '0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (busy_cnt != DEPTH || done_cnt != 1 || done_cyc != DEPTH) begin
      n_fail++;
      $display("FAIL clr_timing busy=%0d done=%0d done_cyc=%0d expected busy=32 done=1 done_cyc=32",
               busy_cnt, done_cnt, done_cyc);
    end
    clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr_a = 5'(a); bus.dbg_addr = 5'(a);
      #1;
      n_tests++;
      if (bus.rd_data_a !== model[a] || bus.dbg_data !== model[a]) begin
        n_fail++;
        $display("FAIL clr_read addr=%0d a=%h dbg=%h expected 0", a, bus.rd_data_a, bus.dbg_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    fill_all();
    pulse_clr_req();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.clr_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midclr_abort busy=%b done=%b state=%0d expected 0", bus.clr_busy, bus.clr_done, bus.clr_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (busy_cnt != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL midclr_after busy=%0d done=%0d expected 0", busy_cnt, done_cnt);
    end
    clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr_b = 5'(a);
      #1;
      n_tests++;
      if (bus.rd_data_b !== model[a]) begin
        n_fail++;
        $display("FAIL midclr_read addr=%0d got=%h expected=%h", a, bus.rd_data_b, model[a]);
      end
    end
  endtask

  task automatic test_bypass();
    drive_write(5'd3, 32'h0, 4'hF);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h12345678; bus.wr_be = 4'b0011;
    bus.rd_addr_a = 5'd3; bus.dbg_addr = 5'd3;
    #1;
    n_tests++;
    if (bus.rd_data_a !== (BYPASS ? 32'h00005678 : 32'h0) || bus.dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_same a=%h dbg=%h expected a=%h dbg=0", bus.rd_data_a, bus.dbg_data,
               BYPASS ? 32'h00005678 : 32'h0);
    end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_be = '0;
    model[3] = 32'h00005678;
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h00005678) begin
      n_fail++;
      $display("FAIL bypass_next got=%h expected=00005678", bus.rd_data_a);
    end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'hF;
    bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
    #1;
    n_tests++;
    if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_zero a=%h b=%h expected 0", bus.rd_data_a, bus.rd_data_b);
    end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_be = '0;
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [4:0]  ra;
    logic [31:0] e;
    for (int k = 0; k < 30; k++) begin
      a = 5'($urandom_range(0, DEPTH - 1));
      drive_write(a, $urandom, 4'($urandom_range(0, 15)));
      ra = 5'($urandom_range(0, DEPTH - 1));
      bus.rd_addr_a = ra;
      exp_q.push_back(model[ra]);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.rd_data_a !== e) begin
        n_fail++;
        $display("FAIL rand_rd addr=%0d got=%h expected=%h", ra, bus.rd_data_a, e);
      end
    end
  endtask

  // sequence and final report
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d entries expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
